// File: rtl/framer_pkg.sv
// Shared types and defaults for the sync-word payload framer.
package framer_pkg;

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_e;

    localparam int unsigned PAYLOAD_W_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned SYNC_LEN      = 5;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register, MSB-first, with synchronous clear and shift enable.
module sipo_shift #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             din_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = {data_q[Width-2:0], din_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/sync_payload_framer.sv
// Captures PAYLOAD_W bits after each sync detection into a one-word valid/ready slot.
// Optional frame counter enabled by defining FRAMER_CNT_EN.
module sync_payload_framer
    import framer_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal,
    input  logic                 det_in,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 drop
`ifdef FRAMER_CNT_EN
    ,
    output logic [CNT_W-1:0]     frame_cnt
`endif
);

    localparam int unsigned CntBits = $clog2(PAYLOAD_W + 1);
    localparam logic [CntBits-1:0] LastCnt = CntBits'(PAYLOAD_W);

    state_e               state_q, state_d;
    logic [CntBits-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CntBits-1:0]   bit_cnt_inc;
    logic [PAYLOAD_W-1:0] shift_q;
    logic [PAYLOAD_W-1:0] word;
    logic                 shift_en;
    logic                 complete;
    logic                 accept;
    logic                 load;

    logic [PAYLOAD_W-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 drop_q, drop_d;

    assign bit_cnt_inc = bit_cnt_q + CntBits'(1);
    // The completing bit is still on the input, so the word is assembled combinationally.
    assign word = {shift_q[PAYLOAD_W-2:0], signal};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (det_in) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = CntBits'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                shift_en = 1'b1;
                if (bit_cnt_inc == LastCnt) begin
                    complete  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    sipo_shift #(
        .Width(PAYLOAD_W)
    ) u_sipo (
        .clk  (clk),
        .rst  (rst),
        .clr_i(complete),
        .en_i (shift_en),
        .din_i(signal),
        .q_o  (shift_q)
    );

    // A slot being drained on this edge counts as free, so a reload wins over the accept.
    assign accept = out_valid_q && out_ready;
    assign load   = complete && (!out_valid_q || accept);

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_d      = complete && !load;
        if (load) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;
    assign busy      = (state_q == CAPTURE);

`ifdef FRAMER_CNT_EN
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (load) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sync_payload_framer.sv
// Scoreboard bench for sync_payload_framer; frame counter checks active with FRAMER_CNT_EN.
module tb_sync_payload_framer;
    import framer_pkg::*;

    localparam int unsigned PW     = 8;
    localparam int unsigned TbCntW = 2;

    logic          clk;
    logic          rst;
    logic          signal;
    logic          det_in;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          drop;
`ifdef FRAMER_CNT_EN
    logic [TbCntW-1:0] frame_cnt;
`endif

    int            checks;
    int            errors;
    int            drops_seen;
    int            exp_cnt;
    logic [PW-1:0] exp_q[$];

    sync_payload_framer #(
        .PAYLOAD_W(PW),
        .CNT_W    (TbCntW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .signal   (signal),
        .det_in   (det_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .drop     (drop)
`ifdef FRAMER_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef FRAMER_CNT_EN
        check(name, 32'(frame_cnt), 32'(exp_cnt % (1 << TbCntW)));
`endif
    endtask

    // Drives one bit for one cycle; assumes entry just after a rising edge.
    task automatic drive_bit(input logic b, input logic d);
        signal = b;
        det_in = d;
        @(posedge clk);
        #2;
    endtask

    // Emulates the upstream 11011 detector: det_in rides with payload bit 0.
    task automatic send_frame(input logic [PW-1:0] w, input bit ready_last, input int inject);
        logic [4:0] sync;
        sync = 5'b11011;
        for (int i = SYNC_LEN - 1; i >= 0; i--) drive_bit(sync[i], 1'b0);
        for (int i = 0; i < int'(PW); i++) begin
            if (ready_last && i == int'(PW) - 1) out_ready = 1'b1;
            if (inject >= 0 && i == inject + 1) check("busy_mid", 32'(busy), 32'd1);
            drive_bit(w[PW-1-i], (i == 0) || (i == inject));
        end
        signal = 1'b0;
        det_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    // Monitor: every word leaving on an accept edge must match the scoreboard head.
    initial begin
        logic [PW-1:0] w;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("word", 32'(out_data), 32'(w));
                end
            end
            if (rst && drop) drops_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        drops_seen = 0;
        exp_cnt    = 0;
        rst        = 1'b0;
        signal     = 1'b0;
        det_in     = 1'b0;
        out_ready  = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check_cnt("rst_cnt");

        // Reset mid-capture after three payload bits.
        out_ready = 1'b1;
        begin
            logic [4:0] sync;
            sync = 5'b11011;
            for (int i = SYNC_LEN - 1; i >= 0; i--) drive_bit(sync[i], 1'b0);
            drive_bit(1'b1, 1'b1);
            drive_bit(1'b0, 1'b0);
            drive_bit(1'b1, 1'b0);
        end
        check("busy_before_rst", 32'(busy), 32'd1);
        signal = 1'b0;
        rst    = 1'b0;
        #1;
        check("busy_in_rst", 32'(busy), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(12);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check_cnt("abort_cnt");

        // Basic capture with ready high.
        exp_q.push_back(8'hA6);
        send_frame(8'hA6, 1'b0, -1);
        exp_cnt++;
        @(negedge clk);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'hA6);
        check_cnt("basic_cnt");
        @(negedge clk);
        check("basic_valid_fall", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;

        // Back-pressure: second word dropped.
        out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, -1);
        exp_cnt++;
        send_frame(8'h81, 1'b0, -1);
        @(negedge clk);
        check("bp_drop", 32'(drop), 32'd1);
        @(negedge clk);
        check("bp_drop_fall", 32'(drop), 32'd0);
        check("bp_data", 32'(out_data), 32'h3C);
        check("bp_valid", 32'(out_valid), 32'd1);
        check_cnt("bp_cnt");
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle(1);
        check("bp_valid_fall", 32'(out_valid), 32'd0);

        // Accept and reload on the same edge.
        out_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, -1);
        exp_cnt++;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1);
        exp_cnt++;
        @(negedge clk);
        check("sim_drop", 32'(drop), 32'd0);
        check("sim_valid", 32'(out_valid), 32'd1);
        check("sim_data", 32'(out_data), 32'hC3);
        check_cnt("sim_cnt");
        @(posedge clk);
        #2;
        check("sim_valid_fall", 32'(out_valid), 32'd0);

        // det_in pulse at payload bit 4 is ignored.
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0, 4);
        exp_cnt++;
        check("pulse_busy_fall", 32'(busy), 32'd0);
        check("pulse_data", 32'(out_data), 32'h96);
        idle(10);
        check("pulse_no_restart", 32'(busy), 32'd0);
        check("pulse_valid", 32'(out_valid), 32'd0);
        check_cnt("pulse_cnt");

        // Further accepted frames wrap the 2-bit counter.
        for (int k = 0; k < 3; k++) begin
            logic [PW-1:0] w;
            w = PW'(8'h11 * (k + 1));
            exp_q.push_back(w);
            send_frame(w, 1'b0, -1);
            exp_cnt++;
            @(negedge clk);
            check("wrap_data", 32'(out_data), 32'(w));
            check_cnt("wrap_cnt");
            @(posedge clk);
            #2;
        end

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("drop_total", 32'(drops_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
